// File: rtl/ref_read_arbiter.sv
// ref_read_arbiter: shares one 256-bit AXI read port among NUM_REQ ReferenceReaders.
// Requests are granted round-robin into a single holding register. Each issued burst
// is logged {owner, len} in an in-order FIFO, and returning beats are steered to the
// owner of the oldest outstanding burst.
// Optional build macro REF_READ_ARB_ERR_CHECK_EN: adds a sticky err_out and drops
// orphan beats (data arriving with no outstanding burst) instead of stalling them.
module ref_read_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned LOG_NUM_REQ     = 2,
   parameter int unsigned ORDER_DEPTH     = 8,
   parameter int unsigned LOG_ORDER_DEPTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ*6-1:0]     req_id_in,
   input  logic [NUM_REQ*32-1:0]    req_addr_in,
   input  logic [NUM_REQ*8-1:0]     req_len_in,
   input  logic [NUM_REQ-1:0]       req_info_valid_in,
   output logic [NUM_REQ-1:0]       req_info_rdy_out,
   output logic [255:0]             req_data_out,
   output logic [NUM_REQ-1:0]       req_data_valid_out,
   input  logic [NUM_REQ-1:0]       req_data_rdy_in,
   output logic [5:0]               rd_id_out,
   output logic [31:0]              rd_addr_out,
   output logic [7:0]               rd_len_out,
   output logic                     rd_info_valid_out,
   input  logic                     rd_info_rdy_in,
   input  logic [255:0]             rd_data_in,
   input  logic                     rd_data_valid_in,
   output logic                     rd_data_rdy_out
`ifdef REF_READ_ARB_ERR_CHECK_EN
   ,
   output logic                     err_out
`endif
);

   localparam int unsigned ID_W    = 6;
   localparam int unsigned ID_HI_W = ID_W - LOG_NUM_REQ;
   localparam int unsigned PW      = LOG_NUM_REQ + 1;
   localparam int unsigned CW      = LOG_ORDER_DEPTH + 1;

   // Per-requester request fields, unpacked from the flat port vectors
   logic [ID_HI_W-1:0]               id_hi_arr [NUM_REQ];
   logic [31:0]                      addr_arr  [NUM_REQ];
   logic [7:0]                       len_arr   [NUM_REQ];
   logic [NUM_REQ*LOG_NUM_REQ-1:0]   unused_id_lsbs;

   // Arbitration
   logic [NUM_REQ-1:0]               eligible;
   logic [LOG_NUM_REQ-1:0]           rr_ptr;
   logic [LOG_NUM_REQ-1:0]           win_idx;
   logic                             win_found;
   logic [LOG_NUM_REQ-1:0]           rr_next;
   logic                             capture;

   // Ordering FIFO and beat tracking
   logic [LOG_NUM_REQ-1:0]           fifo_idx [ORDER_DEPTH];
   logic [7:0]                       fifo_len [ORDER_DEPTH];
   logic [LOG_ORDER_DEPTH-1:0]       wr_ptr;
   logic [LOG_ORDER_DEPTH-1:0]       rd_ptr;
   logic [CW-1:0]                    count;
   logic [7:0]                       beat_cnt;
   logic                             fifo_empty;
   logic                             fifo_full;
   logic [LOG_NUM_REQ-1:0]           head_idx;
   logic [7:0]                       head_len;
   logic                             beat_xfer;
   logic                             pop;

   // Field unpacking; the low ID bits are replaced by the requester index on the bus
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign id_hi_arr[g] = req_id_in[ID_W*g + LOG_NUM_REQ +: ID_HI_W];
      assign addr_arr[g]  = req_addr_in[32*g +: 32];
      assign len_arr[g]   = req_len_in[8*g +: 8];
      assign unused_id_lsbs[LOG_NUM_REQ*g +: LOG_NUM_REQ] = req_id_in[ID_W*g +: LOG_NUM_REQ];
   end

   // A requester acknowledged this cycle still shows its old valid; keep it out of the race
   assign eligible = req_info_valid_in & ~req_info_rdy_out;

   // Round-robin pick: first eligible requester at or after rr_ptr, wrapping
   always_comb begin
      logic [PW-1:0] cand;
      logic [PW-1:0] nxt;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + PW'(k);
         if (cand >= PW'(NUM_REQ)) begin
            cand = cand - PW'(NUM_REQ);
         end
         if (!win_found && eligible[cand[LOG_NUM_REQ-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[LOG_NUM_REQ-1:0];
         end
      end
      nxt = {1'b0, win_idx} + PW'(1);
      if (nxt >= PW'(NUM_REQ)) begin
         nxt = '0;
      end
      rr_next = nxt[LOG_NUM_REQ-1:0];
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(ORDER_DEPTH));
   assign capture    = (!rd_info_valid_out || rd_info_rdy_in) && !fifo_full && win_found;

   assign head_idx   = fifo_idx[rd_ptr];
   assign head_len   = fifo_len[rd_ptr];

   // Return-data steering from the FIFO head
   always_comb begin
      req_data_out       = rd_data_in;
      req_data_valid_out = '0;
      rd_data_rdy_out    = 1'b0;
      if (!fifo_empty) begin
         req_data_valid_out[head_idx] = rd_data_valid_in;
         rd_data_rdy_out              = req_data_rdy_in[head_idx];
      end
`ifdef REF_READ_ARB_ERR_CHECK_EN
      else begin
         rd_data_rdy_out = 1'b1;
      end
`endif
   end

   assign beat_xfer = rd_data_valid_in && rd_data_rdy_out && !fifo_empty;
   assign pop       = beat_xfer && (beat_cnt == head_len);

   // Request holding register, grant pulse, RR pointer and FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_info_valid_out <= 1'b0;
         rd_id_out         <= '0;
         rd_addr_out       <= '0;
         rd_len_out        <= '0;
         req_info_rdy_out  <= '0;
         rr_ptr            <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         beat_cnt          <= '0;
`ifdef REF_READ_ARB_ERR_CHECK_EN
         err_out           <= 1'b0;
`endif
      end else begin
         req_info_rdy_out <= '0;
         if (capture) begin
            rd_info_valid_out         <= 1'b1;
            rd_id_out                 <= {id_hi_arr[win_idx], win_idx};
            rd_addr_out               <= addr_arr[win_idx];
            rd_len_out                <= len_arr[win_idx];
            req_info_rdy_out[win_idx] <= 1'b1;
            rr_ptr                    <= rr_next;
            wr_ptr                    <= wr_ptr + LOG_ORDER_DEPTH'(1);
         end else if (rd_info_rdy_in) begin
            rd_info_valid_out <= 1'b0;
         end

         if (beat_xfer) begin
            if (pop) begin
               beat_cnt <= '0;
               rd_ptr   <= rd_ptr + LOG_ORDER_DEPTH'(1);
            end else begin
               beat_cnt <= beat_cnt + 8'(1);
            end
         end

         case ({capture, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

`ifdef REF_READ_ARB_ERR_CHECK_EN
         if (rd_data_valid_in && fifo_empty) begin
            err_out <= 1'b1;
         end
`endif
      end
   end

   // FIFO payload storage; contents are meaningless while the entry is not counted
   always_ff @(posedge clk) begin
      if (capture) begin
         fifo_idx[wr_ptr] <= win_idx;
         fifo_len[wr_ptr] <= len_arr[win_idx];
      end
   end

   // Interface invariants
   a_rdy_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_info_rdy_out));
   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count <= CW'(ORDER_DEPTH));
   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (rd_info_valid_out && !rd_info_rdy_in) |=>
         (rd_info_valid_out && $stable(rd_id_out) && $stable(rd_addr_out) && $stable(rd_len_out)));

endmodule
